// File: rtl/ln_affine_if.sv
// Bundle of handshake and tile signals between the upstream ln_forward block,
// the ln_affine stage and its consumer. The master side drives the tile,
// gamma, beta and the handshake strobes; the slave side returns the result.
interface ln_affine_if #(
   parameter int IL   = 4,
   parameter int FL   = 16,
   parameter int size = 8
);
   localparam int W = IL + FL;

   logic                input_ready;
   logic                output_taken;
   logic signed [W-1:0] inp   [size][size];
   logic signed [W-1:0] gamma [size];
   logic signed [W-1:0] beta  [size];
   logic signed [W-1:0] out   [size][size];
   logic        [1:0]   state;
   logic                done;

   modport master (
      output input_ready, output_taken, inp, gamma, beta,
      input  out, state, done
   );

   modport slave (
      input  input_ready, output_taken, inp, gamma, beta,
      output out, state, done
   );
endinterface

// File: rtl/ln_affine.sv
// Layer-norm affine stage: out[r][c] = sat(floor(gamma[c]*inp[r][c] / 2^FL) + beta[c]).
// The tile is captured on accept, then one row per clock is pushed through a single
// row of size multipliers addressed by the row counter. The result tile is registered.
module ln_affine #(
   parameter int IL   = 4,
   parameter int FL   = 16,
   parameter int size = 8
) (
   input  logic       clk,
   input  logic       reset,
   ln_affine_if.slave bus
);
   localparam int W     = IL + FL;
   localparam int width = (size > 1) ? $clog2(size) : 1;
   localparam logic [width-1:0] LAST_ROW = width'(size - 1);
   localparam logic [W-1:0]     SAT_MAX  = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0]     SAT_MIN  = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_BUSY = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t              state_q;
   logic                done_q;
   logic [width-1:0]    row_q;
   logic signed [W-1:0] inp_q   [size][size];
   logic signed [W-1:0] gamma_q [size];
   logic signed [W-1:0] beta_q  [size];
   logic signed [W-1:0] out_q   [size][size];
   logic signed [W-1:0] out_row_d [size];

   // One shared datapath column per tile column; the row counter selects which
   // captured row feeds the multipliers this cycle.
   generate
      for (genvar gi = 0; gi < size; gi++) begin : g_col
         logic signed [W-1:0]   x;
         logic signed [2*W-1:0] x_ext;
         logic signed [2*W-1:0] g_ext;
         logic signed [2*W-1:0] prod;
         logic signed [2*W-1:0] quot;
         logic        [2*W:0]   sum;
         logic                  fits;

         assign x     = inp_q[row_q][gi];
         assign x_ext = {{W{x[W-1]}}, x};
         assign g_ext = {{W{gamma_q[gi][W-1]}}, gamma_q[gi]};
         // Exact product: both operands fit in W signed bits, so 2W bits never overflow.
         assign prod  = x_ext * g_ext;
         // Arithmetic shift drops fraction bits, i.e. rounds toward minus infinity.
         assign quot  = prod >>> FL;
         // One guard bit above the product width so the beta add can never wrap.
         assign sum   = {quot[2*W-1], quot} + {{(W+1){beta_q[gi][W-1]}}, beta_q[gi]};
         // Result fits the output word only if every bit above the output sign matches it.
         assign fits  = (sum[2*W:W-1] == {(W+2){1'b0}}) ||
                        (sum[2*W:W-1] == {(W+2){1'b1}});
         assign out_row_d[gi] = fits ? sum[W-1:0] : (sum[2*W] ? SAT_MIN : SAT_MAX);
      end
   endgenerate

   // Control FSM plus capture buffers and the row-by-row result write-back.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         done_q  <= 1'b0;
         row_q   <= '0;
         for (int r = 0; r < size; r++) begin
            gamma_q[r] <= '0;
            beta_q[r]  <= '0;
            for (int c = 0; c < size; c++) begin
               inp_q[r][c] <= '0;
               out_q[r][c] <= '0;
            end
         end
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.input_ready) begin
                  for (int r = 0; r < size; r++) begin
                     gamma_q[r] <= bus.gamma[r];
                     beta_q[r]  <= bus.beta[r];
                     for (int c = 0; c < size; c++) begin
                        inp_q[r][c] <= bus.inp[r][c];
                     end
                  end
                  row_q   <= '0;
                  state_q <= S_BUSY;
               end
            end
            S_BUSY: begin
               for (int c = 0; c < size; c++) begin
                  out_q[row_q][c] <= out_row_d[c];
               end
               if (row_q == LAST_ROW) begin
                  row_q   <= '0;
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else begin
                  row_q <= row_q + 1'b1;
               end
            end
            S_DONE: begin
               if (bus.output_taken) begin
                  state_q <= S_IDLE;
                  done_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < size; gi++) begin : g_out_r
         for (genvar gj = 0; gj < size; gj++) begin : g_out_c
            assign bus.out[gi][gj] = out_q[gi][gj];
         end
      end
   endgenerate

   assign bus.state = state_q;
   assign bus.done  = done_q;
endmodule

// File: tb/tb_ln_affine.sv
// Directed bench for ln_affine: a vector table of size-8 tiles plus hand-written
// handshake, reset and size-16/32 latency sequences.
module tb_ln_affine;
   localparam int W = 20;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ln_affine_if #(.IL(4), .FL(16), .size(8))  bus8 ();
   ln_affine_if #(.IL(4), .FL(16), .size(16)) bus16 ();
   ln_affine_if #(.IL(4), .FL(16), .size(32)) bus32 ();

   ln_affine #(.IL(4), .FL(16), .size(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8.slave));
   ln_affine #(.IL(4), .FL(16), .size(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16.slave));
   ln_affine #(.IL(4), .FL(16), .size(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));

   // mode 0: uniform tile, expv is the hand-computed result
   // mode 1: ramp tile inp=(r*8+c-32)*4096 with identity gamma/beta, out must equal inp
   // mode 2: inp=(r+1)*32768, gamma=(c+1)*8192, beta=c*1000
   typedef struct {
      string name;
      int    mode;
      int    a;
      int    g;
      int    b;
      int    expv;
   } vec_t;

   vec_t vecs [14];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", nm, act, req);
      end
   endtask

   function automatic int in_val(input int mode, input int a, input int r, input int c);
      if (mode == 1) return (r * 8 + c - 32) * 4096;
      if (mode == 2) return (r + 1) * 32768;
      return a;
   endfunction

   function automatic int g_val(input int mode, input int g, input int c);
      if (mode == 2) return (c + 1) * 8192;
      return g;
   endfunction

   function automatic int b_val(input int mode, input int b, input int c);
      if (mode == 2) return c * 1000;
      return b;
   endfunction

   // Mode 2 products are exact multiples of 2^16: (r+1)(c+1)*4096 + c*1000.
   function automatic int ref_val(input int mode, input int expv, input int r, input int c);
      if (mode == 0) return expv;
      if (mode == 1) return in_val(1, 0, r, c);
      return (r + 1) * (c + 1) * 4096 + c * 1000;
   endfunction

   task automatic load8(input int mode, input int a, input int g, input int b);
      for (int r = 0; r < 8; r++) begin
         bus8.gamma[r] = W'(g_val(mode, g, r));
         bus8.beta[r]  = W'(b_val(mode, b, r));
         for (int c = 0; c < 8; c++) bus8.inp[r][c] = W'(in_val(mode, a, r, c));
      end
   endtask

   task automatic load_big();
      for (int r = 0; r < 16; r++) begin
         bus16.gamma[r] = W'(65536);
         bus16.beta[r]  = W'(r * 256);
         for (int c = 0; c < 16; c++) bus16.inp[r][c] = W'(r * 4096);
      end
      for (int r = 0; r < 32; r++) begin
         bus32.gamma[r] = W'(65536);
         bus32.beta[r]  = W'(r * 256);
         for (int c = 0; c < 32; c++) bus32.inp[r][c] = W'(r * 4096);
      end
   endtask

   task automatic check_out8(input string nm, input int mode, input int expv);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            chk($sformatf("%s out[%0d][%0d]", nm, r, c), int'(bus8.out[r][c]),
                ref_val(mode, expv, r, c));
   endtask

   // Full transaction on the size-8 block: accept, wait for done, check, release.
   task automatic run_tile8(input string nm, input int mode, input int a, input int g,
                            input int b, input int expv);
      int lat;
      load8(mode, a, g, b);
      bus8.input_ready = 1'b1;
      @(negedge clk);
      bus8.input_ready = 1'b0;
      chk({nm, " state_busy"}, int'(bus8.state), 1);
      lat = 0;
      while (bus8.done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({nm, " latency"}, lat, 8);
      chk({nm, " state_done"}, int'(bus8.state), 2);
      check_out8(nm, mode, expv);
      bus8.output_taken = 1'b1;
      @(negedge clk);
      bus8.output_taken = 1'b0;
      chk({nm, " state_idle"}, int'(bus8.state), 0);
      chk({nm, " done_low"}, int'(bus8.done), 0);
      $display("tile %s: done after %0d cycles, out[0][0]=%0d out[7][7]=%0d",
               nm, lat, int'(bus8.out[0][0]), int'(bus8.out[7][7]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat16;
      int lat32;

      vecs[0]  = '{"identity",       1, 0,       65536,   0,       0};
      vecs[1]  = '{"scale_shift",    0, 98304,   131072,  -32768,  163840};
      vecs[2]  = '{"sat_pos",        0, 458752,  458752,  0,       524287};
      vecs[3]  = '{"sat_neg",        0, -458752, 458752,  0,       -524288};
      vecs[4]  = '{"trunc_neg",      0, 1,       -1,      0,       -1};
      vecs[5]  = '{"trunc_zero",     0, 1,       1,       0,       0};
      vecs[6]  = '{"half_exact",     0, 100000,  32768,   0,       50000};
      vecs[7]  = '{"half_floor_pos", 0, 100001,  32768,   0,       50000};
      vecs[8]  = '{"half_floor_neg", 0, -100001, 32768,   0,       -50001};
      vecs[9]  = '{"neg_square",     0, -98304,  98304,   0,       -147456};
      vecs[10] = '{"beta_sat_pos",   0, 458752,  65536,   458752,  524287};
      vecs[11] = '{"beta_sat_neg",   0, -458752, 65536,   -458752, -524288};
      vecs[12] = '{"min_times_min",  0, -524288, -524288, 0,       524287};
      vecs[13] = '{"per_column",     2, 0,       0,       0,       0};

      reset = 1'b0;
      bus8.input_ready  = 1'b0;  bus8.output_taken  = 1'b0;
      bus16.input_ready = 1'b0;  bus16.output_taken = 1'b0;
      bus32.input_ready = 1'b0;  bus32.output_taken = 1'b0;
      load8(0, 0, 0, 0);
      load_big();
      repeat (2) @(negedge clk);
      chk("reset state", int'(bus8.state), 0);
      chk("reset done", int'(bus8.done), 0);
      chk("reset out[0][0]", int'(bus8.out[0][0]), 0);
      chk("reset out[7][7]", int'(bus8.out[7][7]), 0);
      reset = 1'b1;
      @(negedge clk);

      // Async reset in the middle of a tile (between edges N+3 and N+4).
      load8(0, 98304, 131072, -32768);
      bus8.input_ready = 1'b1;
      @(negedge clk);
      bus8.input_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid row2 written", int'(bus8.out[2][4]), 163840);
      chk("mid row3 unwritten", int'(bus8.out[3][4]), 0);
      chk("mid state busy", int'(bus8.state), 1);
      #1 reset = 1'b0;
      #1;
      chk("async clr state", int'(bus8.state), 0);
      chk("async clr done", int'(bus8.done), 0);
      chk("async clr out[2][4]", int'(bus8.out[2][4]), 0);
      $display("reset8: aborted tile at N+3, state=%0d", int'(bus8.state));
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("post reset idle", int'(bus8.state), 0);
      run_tile8("after_reset", 0, 98304, 131072, -32768, 163840);

      // input_ready pulsed while BUSY, and upstream changes inputs right after accept.
      load8(0, 98304, 131072, -32768);
      bus8.input_ready = 1'b1;
      @(negedge clk);
      load8(0, 0, 0, 0);
      for (int k = 1; k <= 8; k++) begin
         bus8.input_ready = (k == 3);
         @(negedge clk);
         if (k == 7) chk("busy_pulse done k7", int'(bus8.done), 0);
         if (k == 8) chk("busy_pulse done k8", int'(bus8.done), 1);
      end
      bus8.input_ready = 1'b0;
      check_out8("busy_pulse", 0, 163840);
      bus8.input_ready = 1'b1;
      @(negedge clk);
      bus8.input_ready = 1'b0;
      chk("ready ignored in done", int'(bus8.state), 2);
      $display("busy_pulse: tile completed with captured data, state=%0d", int'(bus8.state));

      // output_taken held high from DONE through the next whole tile.
      load8(0, 65536, 65536, 0);
      bus8.output_taken = 1'b1;
      bus8.input_ready  = 1'b1;
      @(negedge clk);
      chk("taken to idle", int'(bus8.state), 0);
      chk("taken done low", int'(bus8.done), 0);
      @(negedge clk);
      bus8.input_ready = 1'b0;
      chk("accept edge after idle", int'(bus8.state), 1);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 7) chk("held_taken busy k7", int'(bus8.state), 1);
         if (k == 8) begin
            chk("held_taken done k8", int'(bus8.state), 2);
            chk("held_taken done flag", int'(bus8.done), 1);
            check_out8("held_taken", 0, 65536);
         end
      end
      @(negedge clk);
      chk("held_taken exit idle", int'(bus8.state), 0);
      bus8.output_taken = 1'b0;
      $display("held_taken: DONE lasted one cycle, state=%0d", int'(bus8.state));

      for (int i = 0; i < 14; i++)
         run_tile8(vecs[i].name, vecs[i].mode, vecs[i].a, vecs[i].g, vecs[i].b, vecs[i].expv);

      // Size 16 and 32: reset mid-tile, then a full tile and latency check.
      @(negedge clk);
      load_big();
      bus16.input_ready = 1'b1;
      bus32.input_ready = 1'b1;
      @(negedge clk);
      bus16.input_ready = 1'b0;
      bus32.input_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("s16 mid row2", int'(bus16.out[2][3]), 2 * 4096 + 3 * 256);
      chk("s32 mid row2", int'(bus32.out[2][31]), 2 * 4096 + 31 * 256);
      #1 reset = 1'b0;
      #1;
      chk("s16 clr state", int'(bus16.state), 0);
      chk("s16 clr out", int'(bus16.out[2][3]), 0);
      chk("s32 clr state", int'(bus32.state), 0);
      chk("s32 clr out", int'(bus32.out[2][31]), 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      bus16.input_ready = 1'b1;
      bus32.input_ready = 1'b1;
      @(negedge clk);
      bus16.input_ready = 1'b0;
      bus32.input_ready = 1'b0;
      lat16 = -1;
      lat32 = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (lat16 < 0 && bus16.done === 1'b1) lat16 = k;
         if (lat32 < 0 && bus32.done === 1'b1) lat32 = k;
      end
      chk("s16 latency", lat16, 16);
      chk("s32 latency", lat32, 32);
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++)
            chk($sformatf("s16 out[%0d][%0d]", r, c), int'(bus16.out[r][c]), r * 4096 + c * 256);
      for (int r = 0; r < 32; r++)
         for (int c = 0; c < 32; c++)
            chk($sformatf("s32 out[%0d][%0d]", r, c), int'(bus32.out[r][c]), r * 4096 + c * 256);
      bus16.output_taken = 1'b1;
      bus32.output_taken = 1'b1;
      @(negedge clk);
      bus16.output_taken = 1'b0;
      bus32.output_taken = 1'b0;
      chk("s16 idle", int'(bus16.state), 0);
      chk("s32 idle", int'(bus32.state), 0);
      $display("big tiles: size16 done after %0d, size32 done after %0d", lat16, lat32);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
